alu_div_arbiter: RTL and testbench

ALU_DIV_ARBITER -- requirements
Module: alu_div_arbiter

---
 rtl/alu_div_arbiter_pkg.sv | 26 ++
 rtl/alu_div_arbiter_if.sv | 25 ++
 rtl/alu_div_iter.sv | 53 +++++
 rtl/alu_div_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_div_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/alu_div_arbiter_pkg.sv
// Shared tinygpu encodings: core sequencing states plus the divider arbiter FSM
// states and default sizing.
package alu_div_arbiter_pkg;

  localparam int DEF_THREADS = 4;
  localparam int DEF_WIDTH   = 8;

  typedef enum logic [2:0] {
    CORE_IDLE,
    CORE_FETCH,
    CORE_DECODE,
    CORE_REQUEST,
    CORE_WAIT,
    CORE_EXECUTE,
    CORE_UPDATE,
    CORE_DONE
  } core_state_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } div_state_t;

endpackage

// File: rtl/alu_div_arbiter_if.sv
// Request/result bundle between the thread lanes (master) and the shared divider (slave).
interface alu_div_arbiter_if #(
  parameter int THREADS = alu_div_arbiter_pkg::DEF_THREADS,
  parameter int WIDTH   = alu_div_arbiter_pkg::DEF_WIDTH
);

  logic [THREADS-1:0]         req;
  logic [THREADS*WIDTH-1:0]   dividend;
  logic [THREADS*WIDTH-1:0]   divisor;
  logic [THREADS-1:0]         done;
  logic [WIDTH-1:0]           quotient;
  logic                       busy;
  logic [$clog2(THREADS)-1:0] grant_id;

  modport master (
    output req, dividend, divisor,
    input  done, quotient, busy, grant_id
  );

  modport slave (
    input  req, dividend, divisor,
    output done, quotient, busy, grant_id
  );

endinterface

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one shift/subtract step per enabled cycle,
// quotient bits shift in from the right as the dividend shifts out the left.
module alu_div_iter
  import alu_div_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step_en,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_shift = {rem_r, q_r[WIDTH-1]};
    diff      = rem_shift - {1'b0, dsr_r};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r   <= '0;
      rem_r <= '0;
      dsr_r <= '0;
    end else if (start) begin
      q_r   <= dividend;
      rem_r <= '0;
      dsr_r <= divisor;
    end else if (step_en) begin
      // borrow out of the trial subtract means restore the shifted remainder
      if (!diff[WIDTH]) begin
        rem_r <= diff[WIDTH-1:0];
        q_r   <= {q_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= rem_shift[WIDTH-1:0];
        q_r   <= {q_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = q_r;
  assign remainder = rem_r;

endmodule

// File: rtl/alu_div_arbiter.sv
// Round-robin arbiter sharing one iterative divider among THREADS request lanes.
//   state | meaning
//   IDLE  | waiting for a request; round-robin grant from rr_ptr
//   LOAD  | capture granted lane operands, arm iteration counter
//   ITER  | one shift/subtract step per cycle, WIDTH cycles
//   DONE  | publish quotient, pulse done next cycle, advance rr_ptr
module alu_div_arbiter
  import alu_div_arbiter_pkg::*;
#(
  parameter int THREADS = DEF_THREADS,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  alu_div_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(THREADS);
  localparam int CW  = $clog2(WIDTH);

  div_state_t       state;
  div_state_t       state_nxt;

  logic [IDW-1:0]     grant_id_r;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     pick_id;
  logic               pick_valid;
  logic [IDW:0]       cand;
  logic [CW-1:0]      iter_cnt;
  logic               div_zero;
  logic [THREADS-1:0] done_r;
  logic [WIDTH-1:0]   quot_r;

  logic [WIDTH-1:0] dvd_lane [THREADS];
  logic [WIDTH-1:0] dsr_lane [THREADS];
  logic [WIDTH-1:0] sel_dvd;
  logic [WIDTH-1:0] sel_dsr;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_rem;

  logic arb_go;
  logic load_en;
  logic step_en;
  logic busy_c;

  for (genvar g = 0; g < THREADS; g++) begin : g_lane
    assign dvd_lane[g] = bus.dividend[g*WIDTH +: WIDTH];
    assign dsr_lane[g] = bus.divisor[g*WIDTH +: WIDTH];
  end

  assign sel_dvd = dvd_lane[grant_id_r];
  assign sel_dsr = dsr_lane[grant_id_r];

  // Search starts at rr_ptr and wraps; first requesting lane wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < THREADS; i++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(THREADS)) cand = cand - (IDW+1)'(THREADS);
      if (!pick_valid && bus.req[cand[IDW-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = cand[IDW-1:0];
      end
    end
  end

  // No new grant while a done pulse is on the bus; that lane's req is stale.
  assign arb_go = pick_valid && (done_r == '0);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arb_go) state_nxt = LOAD;
      LOAD: state_nxt = (sel_dsr == '0) ? DONE : ITER;
      ITER: if (iter_cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c  = (state != IDLE);
    load_en = (state == LOAD);
    step_en = (state == ITER);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_id_r <= '0;
      rr_ptr     <= '0;
      iter_cnt   <= '0;
      div_zero   <= 1'b0;
      done_r     <= '0;
      quot_r     <= '0;
    end else begin
      if (state == IDLE && arb_go) grant_id_r <= pick_id;

      if (load_en) begin
        iter_cnt <= CW'(WIDTH-1);
        div_zero <= (sel_dsr == '0);
      end else if (step_en && iter_cnt != '0) begin
        iter_cnt <= iter_cnt - CW'(1);
      end

      done_r <= '0;
      if (state == DONE) begin
        done_r <= THREADS'(1) << grant_id_r;
        quot_r <= div_zero ? '1 : div_q;
        rr_ptr <= (grant_id_r == IDW'(THREADS-1)) ? '0 : grant_id_r + IDW'(1);
      end
    end
  end

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (load_en),
    .dividend  (sel_dvd),
    .divisor   (sel_dsr),
    .step_en   (step_en),
    .quotient  (div_q),
    .remainder (div_rem)
  );

  assign bus.done     = done_r;
  assign bus.quotient = quot_r;
  assign bus.busy     = busy_c;
  assign bus.grant_id = grant_id_r;

endmodule

// File: tb/tb_alu_div_arbiter.sv
// Scoreboard bench for the shared divider arbiter: expectations are queued at
// request time and retired by a negedge monitor on each done pulse.
module tb_alu_div_arbiter;

  localparam int THREADS = 4;
  localparam int WIDTH   = 8;

  logic clk;
  logic reset;

  alu_div_arbiter_if #(.THREADS(THREADS), .WIDTH(WIDTH)) bus ();

  alu_div_arbiter #(.THREADS(THREADS), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int lane;
    int q;
    int lat;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   grant_cyc = 0;
  logic busy_prev = 1'b0;
  int   last_q = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_q(input int a, input int b);
    if (b == 0) return 255;
    return a / b;
  endfunction

  always @(negedge clk) begin
    if (bus.busy && !busy_prev) grant_cyc = cyc;
    busy_prev = bus.busy;
    if (bus.done != '0) begin
      if (sb.size() == 0) begin
        chk("spurious_done", int'(bus.done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_vec", int'(bus.done), 1 << e.lane);
        chk("quotient", int'(bus.quotient), e.q);
        chk("latency", cyc - grant_cyc, e.lat);
        chk("grant_id", int'(bus.grant_id), e.lane);
        last_q = e.q;
      end
    end
  end

  task automatic set_ops(input int lane, input int a, input int b);
    bus.dividend[lane*WIDTH +: WIDTH] = WIDTH'(a);
    bus.divisor[lane*WIDTH +: WIDTH]  = WIDTH'(b);
  endtask

  task automatic push_exp(input int lane, input int a, input int b);
    exp_t e;
    e.lane = lane;
    e.q    = model_q(a, b);
    e.lat  = (b == 0) ? 2 : WIDTH + 2;
    sb.push_back(e);
  endtask

  task automatic start_req(input int lane, input int a, input int b);
    set_ops(lane, a, b);
    push_exp(lane, a, b);
    bus.req[lane] = 1'b1;
  endtask

  task automatic wait_dones(input int n, input string tag);
    int seen = 0;
    for (int c = 0; c < 40 * n && seen < n; c++) begin
      @(negedge clk);
      if (bus.done != '0) seen++;
    end
    chk(tag, seen, n);
    bus.req = '0;
    @(negedge clk);
    chk("q_hold", int'(bus.quotient), last_q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ea [4] = '{255, 0, 7, 255};
    int eb [4] = '{1, 5, 255, 255};
    int pulses;

    reset        = 1'b0;
    bus.req      = '0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_quot", int'(bus.quotient), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_grant", int'(bus.grant_id), 0);
    reset = 1'b1;
    @(negedge clk);

    // contention: all lanes held, 0,1,2,3 then lane 0 again
    for (int l = 0; l < THREADS; l++) begin
      set_ops(l, 100, l + 1);
      push_exp(l, 100, l + 1);
    end
    push_exp(0, 100, 1);
    bus.req = '1;
    wait_dones(5, "contention_count");

    start_req(0, 200, 7);
    wait_dones(1, "single_count");

    start_req(2, 55, 0);
    wait_dones(1, "divzero_count");

    // operand hazard: dividend changes while iterating
    start_req(1, 9, 3);
    repeat (4) @(negedge clk);
    chk("hazard_busy", int'(bus.busy), 1);
    bus.dividend[1*WIDTH +: WIDTH] = 8'd255;
    wait_dones(1, "hazard_count");

    for (int i = 0; i < 4; i++) begin
      start_req(1, ea[i], eb[i]);
      wait_dones(1, "edge_count");
    end

    // reset mid-ITER: rr_ptr is now 2, lane 2 in flight
    set_ops(2, 200, 7);
    bus.req = 4'b0100;
    repeat (6) @(negedge clk);
    chk("abort_busy", int'(bus.busy), 1);
    chk("abort_gid", int'(bus.grant_id), 2);
    reset   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_quot", int'(bus.quotient), 0);
    chk("abort_busy0", int'(bus.busy), 0);
    chk("abort_gid0", int'(bus.grant_id), 0);
    reset = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done != '0) pulses++;
    end
    chk("abort_no_done", pulses, 0);

    // after reset the search restarts at lane 0
    set_ops(0, 20, 4);
    set_ops(2, 90, 9);
    push_exp(0, 20, 4);
    push_exp(2, 90, 9);
    bus.req = 4'b0101;
    wait_dones(2, "recover_count");

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
